// File: rtl/fpu_round_sched.sv
// Round-robin front end for one shared rounding unit: arbitrates the requesters, registers the
// winning operand as the rounding-unit input and registers the rounded result with its requester id.
module fpu_round_sched #(
   parameter int EXPONENT_WIDTH    = 11,
   parameter int SIGNIFICAND_WIDTH = 52,
   parameter int NUM_REQ           = 2,
   parameter int ID_W              = $clog2(NUM_REQ)
) (
   input  logic                                       clk,
   input  logic                                       rst_n,
   input  logic                                       cfg_rm_wr,
   input  logic [1:0]                                 cfg_rm,
   output logic [1:0]                                 rm_q,
   input  logic [NUM_REQ-1:0]                         req_valid,
   output logic [NUM_REQ-1:0]                         req_ready,
   input  logic [NUM_REQ-1:0]                         req_sign,
   input  logic [NUM_REQ*EXPONENT_WIDTH-1:0]          req_exponent,
   input  logic [NUM_REQ*(SIGNIFICAND_WIDTH+1)-1:0]   req_significand,
   input  logic [NUM_REQ*3-1:0]                       req_grs,
   output logic                                       rnd_sign,
   output logic [EXPONENT_WIDTH-1:0]                  rnd_exponent,
   output logic [SIGNIFICAND_WIDTH:0]                 rnd_significand,
   output logic                                       rnd_guard,
   output logic                                       rnd_round,
   output logic                                       rnd_sticky,
   output logic [1:0]                                 rnd_mode,
   input  logic                                       rnd_out_sign,
   input  logic [EXPONENT_WIDTH-1:0]                  rnd_out_exponent,
   input  logic [SIGNIFICAND_WIDTH:0]                 rnd_out_significand,
   output logic                                       res_valid,
   input  logic                                       res_ready,
   output logic                                       res_sign,
   output logic [EXPONENT_WIDTH-1:0]                  res_exponent,
   output logic [SIGNIFICAND_WIDTH:0]                 res_significand,
   output logic [ID_W-1:0]                            res_id,
   output logic                                       busy
);

   localparam int EW = EXPONENT_WIDTH;
   localparam int SW = SIGNIFICAND_WIDTH + 1;

   logic            s1Valid_q, s1Valid_d;
   logic            s1Sign_q, s1Sign_d;
   logic [EW-1:0]   s1Exp_q, s1Exp_d;
   logic [SW-1:0]   s1Sig_q, s1Sig_d;
   logic [2:0]      s1Grs_q, s1Grs_d;
   logic [ID_W-1:0] s1Id_q, s1Id_d;
   logic [1:0]      s1Rm_q, s1Rm_d;

   logic            resValid_q, resValid_d;
   logic            resSign_q, resSign_d;
   logic [EW-1:0]   resExp_q, resExp_d;
   logic [SW-1:0]   resSig_q, resSig_d;
   logic [ID_W-1:0] resId_q, resId_d;

   logic [1:0]      rmMode_q, rmMode_d;
   logic [ID_W-1:0] rrPtr_q, rrPtr_d;

   logic            adv2, canIssue, transfer, grantFound;
   logic [ID_W-1:0] grantId, scanIdx;
   logic            selSign;
   logic [EW-1:0]   selExp;
   logic [SW-1:0]   selSig;
   logic [2:0]      selGrs;

   assign adv2     = s1Valid_q && (!resValid_q || res_ready);
   assign canIssue = !s1Valid_q || adv2;
   assign transfer = grantFound && canIssue && rst_n;

   // Scan from the round-robin pointer upward with wrap; first valid requester wins.
   always_comb begin
      grantFound = 1'b0;
      grantId    = '0;
      scanIdx    = '0;
      for (int k = 0; k < NUM_REQ; k++) begin
         scanIdx = ID_W'((int'(rrPtr_q) + k) % NUM_REQ);
         if (!grantFound && req_valid[scanIdx]) begin
            grantFound = 1'b1;
            grantId    = scanIdx;
         end
      end
   end

   always_comb begin
      req_ready = '0;
      if (transfer) begin
         req_ready[grantId] = 1'b1;
      end
   end

   assign selSign = req_sign[grantId];
   assign selExp  = req_exponent[grantId*EW +: EW];
   assign selSig  = req_significand[grantId*SW +: SW];
   assign selGrs  = req_grs[grantId*3 +: 3];

   // The mode copied into the issue register is the pre-write value, so a same-cycle write
   // only affects later operands.
   always_comb begin
      rmMode_d   = cfg_rm_wr ? cfg_rm : rmMode_q;
      rrPtr_d    = rrPtr_q;
      s1Valid_d  = s1Valid_q;
      s1Sign_d   = s1Sign_q;
      s1Exp_d    = s1Exp_q;
      s1Sig_d    = s1Sig_q;
      s1Grs_d    = s1Grs_q;
      s1Id_d     = s1Id_q;
      s1Rm_d     = s1Rm_q;
      resValid_d = resValid_q;
      resSign_d  = resSign_q;
      resExp_d   = resExp_q;
      resSig_d   = resSig_q;
      resId_d    = resId_q;
      if (transfer) begin
         rrPtr_d   = (grantId == ID_W'(NUM_REQ - 1)) ? '0 : grantId + 1'b1;
         s1Valid_d = 1'b1;
         s1Sign_d  = selSign;
         s1Exp_d   = selExp;
         s1Sig_d   = selSig;
         s1Grs_d   = selGrs;
         s1Id_d    = grantId;
         s1Rm_d    = rmMode_q;
      end else if (adv2) begin
         s1Valid_d = 1'b0;
      end
      if (adv2) begin
         resValid_d = 1'b1;
         resSign_d  = rnd_out_sign;
         resExp_d   = rnd_out_exponent;
         resSig_d   = rnd_out_significand;
         resId_d    = s1Id_q;
      end else if (res_ready) begin
         resValid_d = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rmMode_q   <= '0;
         rrPtr_q    <= '0;
         s1Valid_q  <= 1'b0;
         s1Sign_q   <= 1'b0;
         s1Exp_q    <= '0;
         s1Sig_q    <= '0;
         s1Grs_q    <= '0;
         s1Id_q     <= '0;
         s1Rm_q     <= '0;
         resValid_q <= 1'b0;
         resSign_q  <= 1'b0;
         resExp_q   <= '0;
         resSig_q   <= '0;
         resId_q    <= '0;
      end else begin
         rmMode_q   <= rmMode_d;
         rrPtr_q    <= rrPtr_d;
         s1Valid_q  <= s1Valid_d;
         s1Sign_q   <= s1Sign_d;
         s1Exp_q    <= s1Exp_d;
         s1Sig_q    <= s1Sig_d;
         s1Grs_q    <= s1Grs_d;
         s1Id_q     <= s1Id_d;
         s1Rm_q     <= s1Rm_d;
         resValid_q <= resValid_d;
         resSign_q  <= resSign_d;
         resExp_q   <= resExp_d;
         resSig_q   <= resSig_d;
         resId_q    <= resId_d;
      end
   end

   assign rm_q            = rmMode_q;
   assign rnd_sign        = s1Sign_q;
   assign rnd_exponent    = s1Exp_q;
   assign rnd_significand = s1Sig_q;
   assign rnd_guard       = s1Grs_q[2];
   assign rnd_round       = s1Grs_q[1];
   assign rnd_sticky      = s1Grs_q[0];
   assign rnd_mode        = s1Rm_q;
   assign res_valid       = resValid_q;
   assign res_sign        = resSign_q;
   assign res_exponent    = resExp_q;
   assign res_significand = resSig_q;
   assign res_id          = resId_q;
   assign busy            = s1Valid_q | resValid_q;

endmodule

// File: tb/tb_fpu_round_sched.sv
// Directed bench for fpu_round_sched; a small behavioural rounding unit closes the loop
// from rnd_* back to rnd_out_*.
module tb_fpu_round_sched;

   localparam int EW = 11;
   localparam int SW = 53;
   localparam int NR = 2;
   localparam int IW = 1;

   logic              clk = 1'b0;
   logic              rst_n;
   logic              cfg_rm_wr;
   logic [1:0]        cfg_rm;
   logic [1:0]        rm_q;
   logic [NR-1:0]     req_valid;
   logic [NR-1:0]     req_ready;
   logic [NR-1:0]     req_sign;
   logic [NR*EW-1:0]  req_exponent;
   logic [NR*SW-1:0]  req_significand;
   logic [NR*3-1:0]   req_grs;
   logic              rnd_sign, rnd_guard, rnd_round, rnd_sticky;
   logic [EW-1:0]     rnd_exponent;
   logic [SW-1:0]     rnd_significand;
   logic [1:0]        rnd_mode;
   logic              rnd_out_sign;
   logic [EW-1:0]     rnd_out_exponent;
   logic [SW-1:0]     rnd_out_significand;
   logic              res_valid, res_ready, res_sign;
   logic [EW-1:0]     res_exponent;
   logic [SW-1:0]     res_significand;
   logic [IW-1:0]     res_id;
   logic              busy;

   int checks = 0;
   int errors = 0;

   fpu_round_sched #(
      .EXPONENT_WIDTH(EW), .SIGNIFICAND_WIDTH(SW - 1), .NUM_REQ(NR), .ID_W(IW)
   ) dut (
      .clk(clk), .rst_n(rst_n), .cfg_rm_wr(cfg_rm_wr), .cfg_rm(cfg_rm), .rm_q(rm_q),
      .req_valid(req_valid), .req_ready(req_ready), .req_sign(req_sign),
      .req_exponent(req_exponent), .req_significand(req_significand), .req_grs(req_grs),
      .rnd_sign(rnd_sign), .rnd_exponent(rnd_exponent), .rnd_significand(rnd_significand),
      .rnd_guard(rnd_guard), .rnd_round(rnd_round), .rnd_sticky(rnd_sticky),
      .rnd_mode(rnd_mode), .rnd_out_sign(rnd_out_sign), .rnd_out_exponent(rnd_out_exponent),
      .rnd_out_significand(rnd_out_significand), .res_valid(res_valid),
      .res_ready(res_ready), .res_sign(res_sign), .res_exponent(res_exponent),
      .res_significand(res_significand), .res_id(res_id), .busy(busy)
   );

   always #5 clk = ~clk;

   // Behavioural rounding unit: increment on the mode's round-up condition, carry into exponent.
   logic          roundUp;
   logic [SW:0]   sum;
   always_comb begin
      case (rnd_mode)
         2'b00:   roundUp = rnd_guard & (rnd_round | rnd_sticky | rnd_significand[0]);
         2'b01:   roundUp = !rnd_sign & (rnd_guard | rnd_round | rnd_sticky);
         2'b10:   roundUp = rnd_sign & (rnd_guard | rnd_round | rnd_sticky);
         default: roundUp = 1'b0;
      endcase
      sum          = {1'b0, rnd_significand} + {{SW{1'b0}}, roundUp};
      rnd_out_sign = rnd_sign;
      if (sum[SW]) begin
         rnd_out_significand = sum[SW:1];
         rnd_out_exponent    = rnd_exponent + 1'b1;
      end else begin
         rnd_out_significand = sum[SW-1:0];
         rnd_out_exponent    = rnd_exponent;
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic setOperand(input int idx, input logic s, input logic [EW-1:0] e,
                             input logic [SW-1:0] m, input logic [2:0] g);
      req_sign[idx]                = s;
      req_exponent[idx*EW +: EW]   = e;
      req_significand[idx*SW +: SW] = m;
      req_grs[idx*3 +: 3]          = g;
   endtask

   task automatic test_reset();
      rst_n = 1'b0; cfg_rm_wr = 1'b0; cfg_rm = 2'b00; req_valid = '0; req_sign = '0;
      req_exponent = '0; req_significand = '0; req_grs = '0; res_ready = 1'b1;
      repeat (3) tick();
      rst_n = 1'b1;
      tick();
      checks++; if (req_ready !== 2'b00) begin errors++; $display("FAIL reset_ready: got %b want 00", req_ready); end
      checks++; if (res_valid !== 1'b0) begin errors++; $display("FAIL reset_res_valid: got %b want 0", res_valid); end
      checks++; if (rm_q !== 2'b00) begin errors++; $display("FAIL reset_rm: got %b want 00", rm_q); end
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
      checks++; if (res_significand !== '0) begin errors++; $display("FAIL reset_res_sig: got %h want 0", res_significand); end
   endtask

   task automatic test_single();
      setOperand(1, 1'b0, 11'h3FF, 53'h1_0000_0000_0001, 3'b100);
      req_valid = 2'b10;
      #1;
      checks++; if (req_ready !== 2'b10) begin errors++; $display("FAIL single_ready: got %b want 10", req_ready); end
      tick();
      req_valid = 2'b00;
      checks++; if (rnd_significand !== 53'h1_0000_0000_0001 || rnd_guard !== 1'b1 || res_valid !== 1'b0) begin
         errors++; $display("FAIL single_issue: got sig %h g %b rv %b want 1000000000001 1 0", rnd_significand, rnd_guard, res_valid);
      end
      tick();
      checks++; if (res_valid !== 1'b1 || res_id !== 1'b1) begin
         errors++; $display("FAIL single_valid_id: got %b/%b want 1/1", res_valid, res_id);
      end
      checks++; if (res_significand !== 53'h1_0000_0000_0002 || res_exponent !== 11'h3FF || res_sign !== 1'b0) begin
         errors++; $display("FAIL single_value: got %b %h %h want 0 3ff 1000000000002", res_sign, res_exponent, res_significand);
      end
      tick();
      checks++; if (res_valid !== 1'b0 || busy !== 1'b0) begin
         errors++; $display("FAIL single_drain: got rv %b busy %b want 0 0", res_valid, busy);
      end
   endtask

   task automatic test_back_to_back();
      logic [1:0]  expReady;
      logic [SW-1:0] expSig;
      setOperand(0, 1'b0, 11'h100, 53'h10, 3'b000);
      setOperand(1, 1'b0, 11'h200, 53'h20, 3'b000);
      for (int c = 0; c < 8; c++) begin
         req_valid = (c < 6) ? 2'b11 : 2'b00;
         #1;
         if (c < 6) begin
            expReady = (c % 2 == 0) ? 2'b01 : 2'b10;
            checks++; if (req_ready !== expReady) begin
               errors++; $display("FAIL b2b_grant[%0d]: got %b want %b", c, req_ready, expReady);
            end
         end
         if (c >= 2) begin
            expSig = ((c - 2) % 2 == 0) ? 53'h10 : 53'h20;
            checks++; if (res_valid !== 1'b1 || res_id !== IW'((c - 2) % 2) || res_significand !== expSig) begin
               errors++; $display("FAIL b2b_result[%0d]: got v%b id%0d sig %h want v1 id%0d sig %h", c, res_valid, res_id, res_significand, (c - 2) % 2, expSig);
            end
         end
         tick();
      end
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL b2b_idle: got busy %b want 0", busy); end
   endtask

   task automatic test_backpressure();
      int  opIdx;
      logic accepted;
      logic [1:0] expReady;
      opIdx = 0;
      setOperand(0, 1'b0, 11'h3FF, 53'h100, 3'b000);
      req_valid = 2'b01;
      res_ready = 1'b0;
      for (int c = 0; c < 5; c++) begin
         #1;
         expReady = (c < 2) ? 2'b01 : 2'b00;
         checks++; if (req_ready !== expReady) begin
            errors++; $display("FAIL bp_ready[%0d]: got %b want %b", c, req_ready, expReady);
         end
         accepted = req_ready[0];
         tick();
         if (accepted) begin
            opIdx++;
            setOperand(0, 1'b0, 11'h3FF, 53'h100 + SW'(opIdx), 3'b000);
         end
      end
      checks++; if (opIdx !== 2) begin errors++; $display("FAIL bp_accepted: got %0d want 2", opIdx); end
      checks++; if (res_valid !== 1'b1 || res_significand !== 53'h100 || busy !== 1'b1) begin
         errors++; $display("FAIL bp_hold: got v%b sig %h busy %b want v1 sig 100 busy 1", res_valid, res_significand, busy);
      end
      req_valid = 2'b00;
      res_ready = 1'b1;
      #1;
      checks++; if (res_valid !== 1'b1 || res_significand !== 53'h100 || res_id !== 1'b0) begin
         errors++; $display("FAIL bp_drain0: got v%b sig %h id %0d want v1 sig 100 id 0", res_valid, res_significand, res_id);
      end
      tick();
      checks++; if (res_valid !== 1'b1 || res_significand !== 53'h101) begin
         errors++; $display("FAIL bp_drain1: got v%b sig %h want v1 sig 101", res_valid, res_significand);
      end
      tick();
      checks++; if (res_valid !== 1'b0 || busy !== 1'b0) begin
         errors++; $display("FAIL bp_nodup: got v%b busy %b want 0 0", res_valid, busy);
      end
   endtask

   task automatic test_rounding_mode();
      setOperand(0, 1'b0, 11'h3FF, 53'h1F_FFFF_FFFF_FFFF, 3'b111);
      req_valid = 2'b01;
      cfg_rm_wr = 1'b1;
      cfg_rm    = 2'b11;
      #1;
      checks++; if (req_ready !== 2'b01) begin errors++; $display("FAIL rm_accept: got %b want 01", req_ready); end
      tick();
      cfg_rm_wr = 1'b0;
      req_valid = 2'b00;
      checks++; if (rm_q !== 2'b11 || rnd_mode !== 2'b00) begin
         errors++; $display("FAIL rm_sampled: got rm_q %b rnd_mode %b want 11 00", rm_q, rnd_mode);
      end
      tick();
      checks++; if (res_valid !== 1'b1 || res_significand !== 53'h10_0000_0000_0000 || res_exponent !== 11'h400) begin
         errors++; $display("FAIL rm_carry: got v%b exp %h sig %h want v1 exp 400 sig 10000000000000", res_valid, res_exponent, res_significand);
      end
      req_valid = 2'b01;
      tick();
      req_valid = 2'b00;
      checks++; if (rnd_mode !== 2'b11) begin errors++; $display("FAIL rm_new_mode: got %b want 11", rnd_mode); end
      tick();
      checks++; if (res_valid !== 1'b1 || res_significand !== 53'h1F_FFFF_FFFF_FFFF || res_exponent !== 11'h3FF) begin
         errors++; $display("FAIL rm_truncate: got v%b exp %h sig %h want v1 exp 3ff sig 1fffffffffffff", res_valid, res_exponent, res_significand);
      end
      tick();
   endtask

   task automatic test_reset_inflight();
      setOperand(0, 1'b0, 11'h3FF, 53'h200, 3'b000);
      req_valid = 2'b01;
      res_ready = 1'b0;
      tick();
      tick();
      checks++; if (busy !== 1'b1 || res_valid !== 1'b1) begin
         errors++; $display("FAIL rst_pre_busy: got busy %b rv %b want 1 1", busy, res_valid);
      end
      rst_n = 1'b0;
      #1;
      checks++; if (res_valid !== 1'b0 || busy !== 1'b0 || req_ready !== 2'b00) begin
         errors++; $display("FAIL rst_async: got rv %b busy %b ready %b want 0 0 00", res_valid, busy, req_ready);
      end
      checks++; if (rm_q !== 2'b00 || res_significand !== '0 || rnd_significand !== '0) begin
         errors++; $display("FAIL rst_clear: got rm %b res %h rnd %h want 00 0 0", rm_q, res_significand, rnd_significand);
      end
      tick();
      req_valid = 2'b00;
      res_ready = 1'b1;
      rst_n = 1'b1;
      for (int c = 0; c < 3; c++) begin
         tick();
         checks++; if (res_valid !== 1'b0) begin
            errors++; $display("FAIL rst_no_result[%0d]: got %b want 0", c, res_valid);
         end
      end
      req_valid = 2'b11;
      #1;
      checks++; if (req_ready !== 2'b01) begin errors++; $display("FAIL rst_rr_ptr: got %b want 01", req_ready); end
      req_valid = 2'b00;
      tick();
   endtask

   initial begin
      test_reset();
      test_single();
      test_back_to_back();
      test_backpressure();
      test_rounding_mode();
      test_reset_inflight();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL timeout: got no completion want completion");
      $fatal(1, "[TB] timeout");
   end

endmodule
